ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. It is the successor of the single-byte PS/2 receiver and adds an input glitch filter, a mid-frame timeout abort, separate error reporting, and a show-ahead receive FIFO with overflow detection. It sits between the keyboard/mouse pins and the scan-code decoder, which drains bytes at its own pace through rd_en.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_rx_fifo_sync_fifo.sv | 63 ++++++
 rtl/ps2_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int FRAME_DATA_BITS = 8;

    // True when data plus parity carries an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic                       parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// rtl/ps2_rx_fifo_sync_fifo.sv - show-ahead synchronous FIFO with simultaneous push/pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, timeout and receive FIFO
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int FILT_LEN     = 4,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int CHECK_PARITY = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    data_out,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          clr_err,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout
);
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int BW  = $clog2(FRAME_DATA_BITS);

    logic                       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic                       dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic                       filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic [FCW-1:0]             fcnt_q, fcnt_d;
    logic                       strobe;

    ps2_state_t                 state_q, state_d;
    logic [BW-1:0]              bit_idx_q, bit_idx_d;
    logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                       par_q, par_d;
    logic [TW-1:0]              tout_q, tout_d;
    logic                       err_parity_q, err_parity_d;
    logic                       err_frame_q, err_frame_d;
    logic                       err_timeout_q, err_timeout_d;
    logic                       push_q, push_d;
    logic [7:0]                 push_byte_q, push_byte_d;
    logic                       overflow_q, overflow_d;
    logic                       fifo_full;

    // Synchronisers and glitch filter: the filtered clock follows only a level held FILT_LEN cycles.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_dly_d = filt_q;
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    assign strobe = filt_dly_q & ~filt_q;

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        tout_d        = tout_q;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        push_d        = 1'b0;
        push_byte_d   = push_byte_q;
        if (strobe) begin
            tout_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d = {dat_s2_q, shreg_q[FRAME_DATA_BITS-1:1]};
                    if (bit_idx_q == BW'(FRAME_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s2_q) begin
                        err_frame_d = 1'b1;
                    end else if ((CHECK_PARITY != 0) && !odd_parity_ok(shreg_q, par_q)) begin
                        err_parity_d = 1'b1;
                    end else begin
                        push_d      = 1'b1;
                        push_byte_d = shreg_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tout_q == TW'(TIMEOUT_CYC - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = IDLE;
                tout_d        = '0;
            end else begin
                tout_d = tout_q + TW'(1);
            end
        end
    end

    // A dropped byte (full, no simultaneous pop) sets overflow even if clr_err is asserted.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (push_q && fifo_full && !rd_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            filt_dly_q    <= 1'b1;
            fcnt_q        <= '0;
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            tout_q        <= '0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            push_q        <= 1'b0;
            push_byte_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            filt_q        <= filt_d;
            filt_dly_q    <= filt_dly_d;
            fcnt_q        <= fcnt_d;
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            tout_q        <= tout_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            push_q        <= push_d;
            push_byte_q   <= push_byte_d;
            overflow_q    <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .push    (push_q),
        .wr_data (push_byte_q),
        .pop     (rd_en),
        .rd_data (data_out),
        .count   (count),
        .empty   (empty),
        .full    (fifo_full)
    );

    assign overflow    = overflow_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo (parity-checking and parity-ignoring instances)
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TOUT  = 300;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       clr_err = 1'b0;
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic [7:0] data_out_a, data_out_b;
    logic       empty_a, empty_b, overflow_a, overflow_b;
    logic [3:0] count_a, count_b;
    logic       err_par_a, err_frm_a, err_to_a;
    logic       err_par_b, err_frm_b, err_to_b;

    int checks = 0;
    int failures = 0;
    bit auto_drain = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int n_par_a = 0, n_frm_a = 0, n_to_a = 0;
    int n_par_b = 0, n_frm_b = 0, n_to_b = 0;
    int exp_par = 0, exp_frm = 0, exp_to = 0;

    always #5 sys_clk = ~sys_clk;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT_CYC(TOUT), .CHECK_PARITY(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en_a), .data_out(data_out_a), .empty(empty_a), .count(count_a),
        .overflow(overflow_a), .clr_err(clr_err), .err_parity(err_par_a),
        .err_frame(err_frm_a), .err_timeout(err_to_a));

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT_CYC(TOUT), .CHECK_PARITY(0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en_b), .data_out(data_out_b), .empty(empty_b), .count(count_b),
        .overflow(overflow_b), .clr_err(clr_err), .err_parity(err_par_b),
        .err_frame(err_frm_b), .err_timeout(err_to_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_errs(input string name);
        chk({name, "_err_parity"}, n_par_a, exp_par);
        chk({name, "_err_frame"}, n_frm_a, exp_frm);
        chk({name, "_err_timeout"}, n_to_a, exp_to);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Error pulse counters, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (err_par_a) n_par_a++;
            if (err_frm_a) n_frm_a++;
            if (err_to_a)  n_to_a++;
            if (err_par_b) n_par_b++;
            if (err_frm_b) n_frm_b++;
            if (err_to_b)  n_to_b++;
        end
    end

    // Scoreboard monitor for the parity-checking instance (drains only when enabled).
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rd_en_a) begin
                rd_en_a = 1'b0;
            end else if (auto_drain && !empty_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_a_unexpected: got 0x%0h expected no byte", data_out_a);
                end else begin
                    chk("rx_a_byte", data_out_a, qa.pop_front());
                end
                rd_en_a = 1'b1;
            end
        end
    end

    // Scoreboard monitor for the parity-ignoring instance (always drains).
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rd_en_b) begin
                rd_en_b = 1'b0;
            end else if (!empty_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_b_unexpected: got 0x%0h expected no byte", data_out_b);
                end else begin
                    chk("rx_b_byte", data_out_b, qb.pop_front());
                end
                rd_en_b = 1'b1;
            end
        end
    end

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        cycles(10);
        if (glitch) begin
            ps2_clk = 1'b0;
            cycles(FILT - 1);
            ps2_clk = 1'b1;
            cycles(10);
        end
        ps2_clk = 1'b0;
        cycles(20);
        ps2_clk = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            cycles(1);
            n++;
        end
        chk({name, "_drain_left"}, qa.size() + qb.size(), 0);
        cycles(4);
    endtask

    initial begin
        cycles(5);
        sys_rst = 1'b0;
        cycles(2);
        chk("rst_empty", empty_a, 1);
        chk("rst_count", count_a, 0);
        chk("rst_data_out", data_out_a, 0);
        chk("rst_overflow", overflow_a, 0);
        chk_errs("rst");

        // Good frame 0x1C held, then drained.
        qa.push_back(8'h1C); qb.push_back(8'h1C);
        send_frame(8'h1C, 0, 1, 11, 0);
        cycles(5);
        chk("f1c_empty", empty_a, 0);
        chk("f1c_count", count_a, 1);
        chk("f1c_data_out", data_out_a, 8'h1C);
        chk_errs("f1c");
        auto_drain = 1'b1;
        wait_drain("f1c");
        chk("f1c_rd_empty", empty_a, 1);
        chk("f1c_rd_count", count_a, 0);

        // Bad parity: rejected by A, stored by B.
        qb.push_back(8'h1C);
        send_frame(8'h1C, 1, 1, 11, 0);
        exp_par++;
        wait_drain("badpar");
        chk_errs("badpar");
        chk("badpar_count", count_a, 0);

        // Bad start bit, then bad stop bit.
        send_bit(1'b1, 0);
        exp_frm++;
        send_frame(8'h33, 0, 0, 11, 0);
        exp_frm++;
        cycles(40);
        chk_errs("badframe");
        chk("badframe_count", count_a, 0);

        // Overflow: nine frames into an eight-deep FIFO.
        auto_drain = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) qa.push_back(8'(i));
            qb.push_back(8'(i));
            send_frame(8'(i), 0, 1, 11, 0);
        end
        cycles(5);
        chk("ovf_count", count_a, DEPTH);
        chk("ovf_flag", overflow_a, 1);
        chk("ovf_head", data_out_a, 8'h01);
        auto_drain = 1'b1;
        wait_drain("ovf");
        chk("ovf_drain_count", count_a, 0);
        chk("ovf_sticky", overflow_a, 1);
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        chk("ovf_clr", overflow_a, 0);
        chk_errs("ovf");

        // Timeout after five bits, then a clean 0xF0.
        send_frame(8'h55, 0, 1, 5, 0);
        cycles(TOUT + 50);
        exp_to++;
        chk_errs("tout");
        qa.push_back(8'hF0); qb.push_back(8'hF0);
        send_frame(8'hF0, 0, 1, 11, 0);
        wait_drain("tout_next");
        chk_errs("tout_next");

        // Sub-filter low pulses in idle and inside every bit of 0xAA.
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            cycles(FILT - 1);
            ps2_clk = 1'b1;
            cycles(8);
        end
        qa.push_back(8'hAA); qb.push_back(8'hAA);
        send_frame(8'hAA, 0, 1, 11, 1);
        wait_drain("glitch");
        chk_errs("glitch");

        // Reset mid-frame, then 0x5A.
        auto_drain = 1'b0;
        send_frame(8'hC3, 0, 1, 6, 0);
        sys_rst = 1'b1;
        cycles(3);
        sys_rst = 1'b0;
        cycles(TOUT + 100);
        chk_errs("rstmid");
        qa.push_back(8'h5A); qb.push_back(8'h5A);
        send_frame(8'h5A, 0, 1, 11, 0);
        cycles(5);
        chk("rstmid_count", count_a, 1);
        chk("rstmid_data_out", data_out_a, 8'h5A);
        auto_drain = 1'b1;
        wait_drain("rstmid");
        chk_errs("rstmid_end");

        chk("b_err_parity", n_par_b, 0);
        chk("b_err_frame", n_frm_b, exp_frm);
        chk("b_err_timeout", n_to_b, exp_to);
        chk("b_overflow", overflow_b, 0);
        chk("b_count", count_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
